// File: rtl/connect4_temporizador_if.sv
// Bundle between the game controller/board and the per-turn timer:
// turn enables and column status in, expiry flags and automatic column out.
interface connect4_temporizador_if;
    logic       enTurno1;
    logic       enTurno2;
    logic [6:0] col_llena;
    logic       tiempo_terminado_J1;
    logic       tiempo_terminado_J2;
    logic       random_valido_J1;
    logic       random_valido_J2;
    logic [2:0] col_random;
    logic [3:0] segundos_restantes;
    logic       tablero_lleno;

    modport master (
        output enTurno1,
        output enTurno2,
        output col_llena,
        input  tiempo_terminado_J1,
        input  tiempo_terminado_J2,
        input  random_valido_J1,
        input  random_valido_J2,
        input  col_random,
        input  segundos_restantes,
        input  tablero_lleno
    );

    modport slave (
        input  enTurno1,
        input  enTurno2,
        input  col_llena,
        output tiempo_terminado_J1,
        output tiempo_terminado_J2,
        output random_valido_J1,
        output random_valido_J2,
        output col_random,
        output segundos_restantes,
        output tablero_lleno
    );
endinterface

// File: rtl/connect4_temporizador.sv
// Per-turn countdown and automatic-move generator for Connect-4.
// Define CONNECT4_RANDOM_EN to start the column search at an LFSR-chosen column.
module connect4_temporizador #(
    parameter int CICLOS_POR_SEG = 50_000_000,
    parameter int TURNO_SEG      = 10,
    parameter int GAP_MAX        = 4
) (
    input logic                    clk,
    input logic                    rst,
    connect4_temporizador_if.slave bus
);

    localparam int PW = (CICLOS_POR_SEG > 1) ? $clog2(CICLOS_POR_SEG) : 1;
    localparam int GW = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;
    localparam logic [PW-1:0] PRESC_ULT = PW'(CICLOS_POR_SEG - 1);
    localparam logic [GW-1:0] GAP_ULT   = GW'(GAP_MAX - 1);
    localparam logic [3:0]    SEG_INI   = 4'(TURNO_SEG);

    typedef enum logic [2:0] {
        INACTIVO,
        CONTANDO,
        BUSCANDO,
        LISTO,
        LLENO
    } estado_t;

    estado_t       estado, estado_sig;
    logic          dueno, dueno_sig;
    logic [3:0]    seg, seg_sig;
    logic [PW-1:0] presc, presc_sig;
    logic [GW-1:0] gap, gap_sig;
    logic [2:0]    cand, cand_sig;
    logic [2:0]    intentos, intentos_sig;
    logic [2:0]    col, col_sig;
    logic [7:0]    lfsr, lfsr_sig;

    logic       en;
    logic       o;
    logic       reiniciar;
    logic       lfsr_fb;
    logic [2:0] cand_ini;
    logic [7:0] llena_ext;

    assign en        = bus.enTurno1 | bus.enTurno2;
    assign o         = bus.enTurno2;
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    // Bit 7 never gets selected (cand stays 0..6); it only keeps the index in range.
    assign llena_ext = {1'b1, bus.col_llena};

`ifdef CONNECT4_RANDOM_EN
    assign cand_ini = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
`else
    assign cand_ini = 3'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= INACTIVO;
            dueno    <= 1'b0;
            seg      <= 4'd0;
            presc    <= '0;
            gap      <= '0;
            cand     <= 3'd0;
            intentos <= 3'd0;
            col      <= 3'd0;
            lfsr     <= 8'hA5;
        end else begin
            estado   <= estado_sig;
            dueno    <= dueno_sig;
            seg      <= seg_sig;
            presc    <= presc_sig;
            gap      <= gap_sig;
            cand     <= cand_sig;
            intentos <= intentos_sig;
            col      <= col_sig;
            lfsr     <= lfsr_sig;
        end
    end

    always_comb begin
        estado_sig   = estado;
        dueno_sig    = dueno;
        seg_sig      = seg;
        presc_sig    = presc;
        gap_sig      = gap;
        cand_sig     = cand;
        intentos_sig = intentos;
        col_sig      = col;
        lfsr_sig     = {lfsr[6:0], lfsr_fb};
        reiniciar    = 1'b0;

        case (estado)
            INACTIVO: begin
                reiniciar = en;
            end

            CONTANDO: begin
                if (en && (o != dueno)) begin
                    reiniciar = 1'b1;
                end else begin
                    gap_sig = en ? '0 : gap + 1'b1;
                    if (presc == PRESC_ULT) begin
                        presc_sig = '0;
                        if (seg == 4'd1) begin
                            seg_sig      = 4'd0;
                            estado_sig   = BUSCANDO;
                            cand_sig     = cand_ini;
                            intentos_sig = 3'd0;
                        end else begin
                            seg_sig = seg - 4'd1;
                        end
                    end else begin
                        presc_sig = presc + 1'b1;
                    end
                    // A long silence means the game ended or the menu is up.
                    if (!en && (gap == GAP_ULT)) begin
                        estado_sig = INACTIVO;
                    end
                end
            end

            BUSCANDO: begin
                if (en && (o != dueno)) begin
                    reiniciar = 1'b1;
                end else if (!llena_ext[cand]) begin
                    col_sig    = cand;
                    estado_sig = LISTO;
                end else begin
                    cand_sig     = (cand == 3'd6) ? 3'd0 : cand + 3'd1;
                    intentos_sig = intentos + 3'd1;
                    if (intentos == 3'd6) begin
                        estado_sig = LLENO;
                    end
                end
            end

            LISTO, LLENO: begin
                reiniciar = en;
            end

            default: begin
                estado_sig = INACTIVO;
            end
        endcase

        // Restart wins over tick, expiry and gap timeout in the same cycle.
        if (reiniciar) begin
            estado_sig = CONTANDO;
            dueno_sig  = o;
            seg_sig    = SEG_INI;
            presc_sig  = '0;
            gap_sig    = '0;
        end
    end

    logic fin_turno;
    assign fin_turno = (estado == BUSCANDO) || (estado == LISTO) || (estado == LLENO);

    assign bus.tiempo_terminado_J1 = fin_turno && !dueno;
    assign bus.tiempo_terminado_J2 = fin_turno && dueno;
    assign bus.random_valido_J1    = (estado == LISTO) && !dueno;
    assign bus.random_valido_J2    = (estado == LISTO) && dueno;
    assign bus.tablero_lleno       = (estado == LLENO);
    assign bus.col_random          = col;
    assign bus.segundos_restantes  = seg;

endmodule

// File: tb/tb_connect4_temporizador.sv
// Scoreboard bench for connect4_temporizador (4 cycles/s, 3 s turns, gap 4).
// Exact column and search latency are only checked when CONNECT4_RANDOM_EN is undefined.
module tb_connect4_temporizador;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    typedef struct {
        string  tag;
        integer val;
    } exp_t;

    exp_t sb[$];

`ifdef CONNECT4_RANDOM_EN
    localparam logic [11:0] VMASK = 12'hF8F;
`else
    localparam logic [11:0] VMASK = 12'hFFF;
`endif

    connect4_temporizador_if bus ();

    connect4_temporizador #(
        .CICLOS_POR_SEG(4),
        .TURNO_SEG     (3),
        .GAP_MAX       (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic integer mk(input logic t1, input logic t2, input logic r1, input logic r2,
                                  input logic ll, input logic [2:0] c, input logic [3:0] s);
        integer v;
        v = 0;
        v[11:0] = {t1, t2, r1, r2, ll, c, s};
        return v & VMASK;
    endfunction

    function automatic integer obs();
        integer v;
        v = 0;
        v[11:0] = {bus.tiempo_terminado_J1, bus.tiempo_terminado_J2, bus.random_valido_J1,
                   bus.random_valido_J2, bus.tablero_lleno, bus.col_random, bus.segundos_restantes};
        return v;
    endfunction

    task automatic push_exp(input string tag, input integer v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic e1, input logic e2);
        bus.enTurno1 = e1;
        bus.enTurno2 = e2;
    endtask

    // Plays one turn from the current negedge: enable held unless gaps[k] is set,
    // released once expiry shows; records when expiry and the final state appear.
    task automatic run_turn(input logic p2, input logic [31:0] gaps, input int budget,
                            input bit stop_at_tt, output integer seg_first, output integer t_tt,
                            output integer v_tt, output integer t_end, output integer v_end);
        bit seen;
        bit done;
        seen = 0;
        done = 0;
        seg_first = -1;
        t_tt = -1;
        v_tt = -1;
        t_end = -1;
        v_end = -1;
        for (int k = 0; k < budget && !done; k++) begin
            if (k == 1) seg_first = bus.segundos_restantes;
            if (k >= 1) begin
                if (!seen && (bus.tiempo_terminado_J1 || bus.tiempo_terminado_J2)) begin
                    seen = 1;
                    t_tt = cyc;
                    v_tt = obs();
                    if (stop_at_tt) done = 1;
                end else if (seen && (bus.random_valido_J1 || bus.random_valido_J2 || bus.tablero_lleno)) begin
                    t_end = cyc;
                    v_end = obs();
                    done = 1;
                end
            end
            if (seen || done) drive(1'b0, 1'b0);
            else if (k < 32 && gaps[k[4:0]]) drive(1'b0, 1'b0);
            else drive(!p2, p2);
            if (!done) @(negedge clk);
        end
        drive(1'b0, 1'b0);
        if (t_end < 0) v_end = obs();
    endtask

    task automatic test_reset();
        integer got[$];
        exp_t   e;
        integer g;
        rst = 1'b1;
        drive(1'b0, 1'b0);
        bus.col_llena = 7'h00;
        repeat (3) @(negedge clk);
        push_exp("reset_outputs", 0);
        got.push_back(obs());
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_exp("idle_after_reset", 0);
        got.push_back(obs());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: observed %0d, expected %0d", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_expiry_j1();
        integer got[$];
        exp_t   e;
        integer g, n, s0, tt, vtt, te, vend;
        bus.col_llena = 7'h00;
        n = cyc + 1;
        push_exp("j1_seg_start", 3);
        push_exp("j1_expiry_cycle", n + 12);
        push_exp("j1_expiry_outputs", mk(1, 0, 0, 0, 0, 3'd0, 4'd0));
        push_exp("j1_ready_cycle", n + 13);
        push_exp("j1_ready_outputs", mk(1, 0, 1, 0, 0, 3'd0, 4'd0));
        run_turn(1'b0, 32'hAAAA_AAAA, 40, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(vtt & VMASK);
        got.push_back(te);
        got.push_back(vend & VMASK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: observed %0d, expected %0d", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_partial_board_j2();
        integer got[$];
        exp_t   e;
        integer g, n, s0, tt, vtt, te, vend;
        bus.col_llena = 7'b0000111;
        n = cyc + 1;
        push_exp("j2_seg_start", 3);
        push_exp("j2_expiry_cycle", n + 12);
        push_exp("j2_expiry_outputs", mk(0, 1, 0, 0, 0, 3'd0, 4'd0));
`ifdef CONNECT4_RANDOM_EN
        push_exp("j2_ready_in_window", 1);
`else
        push_exp("j2_ready_cycle", n + 16);
`endif
        push_exp("j2_ready_outputs", mk(0, 1, 0, 1, 0, 3'd3, 4'd0));
        run_turn(1'b1, 32'h0, 40, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(vtt & VMASK);
`ifdef CONNECT4_RANDOM_EN
        got.push_back((te >= n + 13 && te <= n + 19) ? 1 : 0);
`else
        got.push_back(te);
`endif
        got.push_back(vend & VMASK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: observed %0d, expected %0d", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_board_full();
        integer got[$];
        exp_t   e;
        integer g, n, s0, tt, vtt, te, vend;
        bus.col_llena = 7'h7F;
        n = cyc + 1;
        push_exp("full_seg_start", 3);
        push_exp("full_expiry_cycle", n + 12);
        push_exp("full_expiry_outputs", mk(1, 0, 0, 0, 0, 3'd3, 4'd0));
        push_exp("full_lleno_cycle", n + 19);
        push_exp("full_lleno_outputs", mk(1, 0, 0, 0, 1, 3'd3, 4'd0));
        run_turn(1'b0, 32'h0, 40, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(vtt & VMASK);
        got.push_back(te);
        got.push_back(vend & VMASK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: observed %0d, expected %0d", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_owner_switch();
        integer got[$];
        exp_t   e;
        integer g, s, s0, tt, vtt, te, vend;
        bus.col_llena = 7'h00;
        push_exp("switch_j1_midcount", mk(0, 0, 0, 0, 0, 3'd3, 4'd2));
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0);
            @(negedge clk);
        end
        got.push_back(obs() & VMASK);
        s = cyc + 1;
        push_exp("switch_seg_restart", 3);
        push_exp("switch_j2_expiry_cycle", s + 12);
        push_exp("switch_j2_expiry_outputs", mk(0, 1, 0, 0, 0, 3'd3, 4'd0));
        push_exp("switch_j2_ready_cycle", s + 13);
        push_exp("switch_j2_ready_outputs", mk(0, 1, 0, 1, 0, 3'd0, 4'd0));
        run_turn(1'b1, 32'h0, 40, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(vtt & VMASK);
        got.push_back(te);
        got.push_back(vend & VMASK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: observed %0d, expected %0d", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_gap_timeout();
        integer got[$];
        exp_t   e;
        integer g, n, s0, tt, vtt, te, vend;
        bus.col_llena = 7'h00;
        // Three idle cycles are tolerated: the count must keep its schedule.
        n = cyc + 1;
        push_exp("gap3_seg_start", 3);
        push_exp("gap3_expiry_cycle", n + 12);
        push_exp("gap3_ready_cycle", n + 13);
        push_exp("gap3_ready_outputs", mk(1, 0, 1, 0, 0, 3'd0, 4'd0));
        run_turn(1'b0, 32'h0000_00E0, 40, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(te);
        got.push_back(vend & VMASK);
        // Four idle cycles abandon the count: no expiry ever follows.
        n = cyc + 1;
        push_exp("gap4_seg_start", 3);
        push_exp("gap4_no_expiry", -1);
        push_exp("gap4_idle_flags", 0);
        run_turn(1'b0, 32'hFFFF_FFE0, 30, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(vend & 12'hF80);
        n = cyc + 1;
        push_exp("gap4_fresh_seg", 3);
        push_exp("gap4_fresh_expiry_cycle", n + 12);
        push_exp("gap4_fresh_ready_outputs", mk(1, 0, 1, 0, 0, 3'd0, 4'd0));
        run_turn(1'b0, 32'h0, 40, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(vend & VMASK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: observed %0d, expected %0d", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_reset_in_search();
        integer got[$];
        exp_t   e;
        integer g, n, s0, tt, vtt, te, vend;
        bus.col_llena = 7'h7F;
        n = cyc + 1;
        push_exp("search_expiry_cycle", n + 12);
        push_exp("search_expiry_outputs", mk(0, 1, 0, 0, 0, 3'd0, 4'd0));
        push_exp("search_reset_outputs", 0);
        push_exp("search_after_release", 0);
        run_turn(1'b1, 32'h0, 40, 1'b1, s0, tt, vtt, te, vend);
        got.push_back(tt);
        got.push_back(vtt & VMASK);
        rst = 1'b1;
        #1;
        got.push_back(obs());
        @(negedge clk);
        rst = 1'b0;
        bus.col_llena = 7'h00;
        repeat (2) @(negedge clk);
        got.push_back(obs());
        n = cyc + 1;
        push_exp("post_reset_seg_start", 3);
        push_exp("post_reset_expiry_cycle", n + 12);
        push_exp("post_reset_ready_cycle", n + 13);
        run_turn(1'b0, 32'h0, 40, 1'b0, s0, tt, vtt, te, vend);
        got.push_back(s0);
        got.push_back(tt);
        got.push_back(te);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e.val) begin
                fails++;
                $display("[TB] FAIL %s: observed %0d, expected %0d", e.tag, g, e.val);
            end
        end
    endtask

    initial begin
        bus.enTurno1  = 1'b0;
        bus.enTurno2  = 1'b0;
        bus.col_llena = 7'h00;
        test_reset();
        test_expiry_j1();
        test_partial_board_j2();
        test_board_full();
        test_owner_switch();
        test_gap_timeout();
        test_reset_in_search();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
